// File: rtl/exp_series_engine.sv
// exp_series_engine: evaluates e^x or e^-x as a truncated Taylor series, each term = prev * x * (1/k).
// One shared multiplier serves both x and 1/k steps; the run ends early once a term drops to the threshold.
module exp_series_engine #(
    parameter int W     = 16,
    parameter int FRAC  = 8,
    parameter int TERMS = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [W-1:0]                 x,
    input  logic [W-1:0]                 thr,
    input  logic                         neg,
    output logic                         busy,
    output logic                         done,
    output logic [W-1:0]                 result,
    output logic [$clog2(TERMS+1)-1:0]   terms_used,
    output logic                         ovf
);

    localparam int CW = $clog2(TERMS+1);
    localparam int KW = $clog2(TERMS);
    localparam logic [W-1:0]  ONE    = W'(1) << FRAC;
    localparam logic [KW-1:0] K_LAST = KW'(TERMS-1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULX,
        S_MULR,
        S_ACC,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]  x_q, x_d;
    logic [W-1:0]  thr_q, thr_d;
    logic          neg_q, neg_d;
    logic [W-1:0]  tmp_q, tmp_d;
    logic [W-1:0]  ans_q, ans_d;
    logic [KW-1:0] k_q, k_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    // Reciprocal table floor(ONE/k); entry 0 is never addressed during a run.
    logic [W-1:0] rom [TERMS];
    for (genvar g = 0; g < TERMS; g++) begin : g_rom
        assign rom[g] = W'((2**FRAC) / ((g == 0) ? 1 : g));
    end

    logic [W-1:0]   mul_b;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] prod_sh;
    logic           prod_ovf;
    logic [W:0]     sum;

    assign mul_b    = (state_q == S_MULX) ? x_q : rom[k_q];
    assign prod     = {{W{1'b0}}, tmp_q} * {{W{1'b0}}, mul_b};
    assign prod_sh  = prod >> FRAC;
    assign prod_ovf = |prod_sh[2*W-1:W];
    assign sum      = {1'b0, ans_q} + {1'b0, tmp_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_MULX;
            S_MULX: state_d = S_MULR;
            S_MULR: state_d = S_ACC;
            S_ACC: begin
                if ((tmp_q <= thr_q) || (k_q == K_LAST)) state_d = S_DONE;
                else                                       state_d = S_MULX;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_MULX) || (state_q == S_MULR) || (state_q == S_ACC);
        done = (state_q == S_DONE);
    end

    always_comb begin
        x_d   = x_q;
        thr_d = thr_q;
        neg_d = neg_q;
        tmp_d = tmp_q;
        ans_d = ans_q;
        k_d   = k_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d   = x;
                    thr_d = thr;
                    neg_d = neg;
                    tmp_d = ONE;
                    ans_d = ONE;
                    k_d   = KW'(1);
                    cnt_d = CW'(1);
                    ovf_d = 1'b0;
                end
            end
            S_MULX, S_MULR: begin
                if (prod_ovf) begin
                    tmp_d = '1;
                    ovf_d = 1'b1;
                end else begin
                    tmp_d = prod_sh[W-1:0];
                end
            end
            S_ACC: begin
                if (tmp_q > thr_q) begin
                    // Odd powers carry the sign when evaluating e^-x.
                    if (neg_q && k_q[0]) begin
                        if (tmp_q > ans_q) begin
                            ans_d = '0;
                            ovf_d = 1'b1;
                        end else begin
                            ans_d = ans_q - tmp_q;
                        end
                    end else if (sum[W]) begin
                        ans_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        ans_d = sum[W-1:0];
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (k_q != K_LAST) k_d = k_q + KW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q   <= '0;
            thr_q <= '0;
            neg_q <= 1'b0;
            tmp_q <= '0;
            ans_q <= '0;
            k_q   <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            thr_q <= thr_d;
            neg_q <= neg_d;
            tmp_q <= tmp_d;
            ans_q <= ans_d;
            k_q   <= k_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign result     = ans_q;
    assign terms_used = cnt_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_exp_series_engine.sv
// Scoreboard bench for exp_series_engine: stimulus pushes expected results, a negedge monitor pops on done.
module tb_exp_series_engine;

    localparam int W     = 16;
    localparam int FRAC  = 8;
    localparam int TERMS = 8;
    localparam int CW    = $clog2(TERMS+1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  x;
    logic [W-1:0]  thr;
    logic          neg;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic [CW-1:0] terms_used;
    logic          ovf;

    exp_series_engine #(.W(W), .FRAC(FRAC), .TERMS(TERMS)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .x          (x),
        .thr        (thr),
        .neg        (neg),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .terms_used (terms_used),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [W-1:0] res;
        int           terms;
        logic         ovf;
        int           e0;
        int           lat;
        string        name;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done at edge %0d expected none", edge_cnt);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check({e.name, "_result"}, 32'(result), 32'(e.res));
                check({e.name, "_terms"}, 32'(terms_used), 32'(e.terms));
                check({e.name, "_ovf"}, 32'(ovf), 32'(e.ovf));
                check({e.name, "_latency"}, 32'(edge_cnt - e.e0), 32'(e.lat));
            end
        end
    end

    task automatic issue(input string name, input logic [W-1:0] xv, input logic [W-1:0] thrv,
                         input logic nv, input logic [W-1:0] er, input int et, input logic eo,
                         input int lat);
        exp_t e;
        @(negedge clk);
        x     = xv;
        thr   = thrv;
        neg   = nv;
        start = 1'b1;
        e = '{er, et, eo, edge_cnt + 1, lat, name};
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
        x     = 16'hA5A5;
        thr   = 16'h0003;
        neg   = ~nv;
        check({name, "_busy"}, 32'(busy), 32'd1);
        check({name, "_ovf_clr"}, 32'(ovf), 32'd0);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((sbq.size() != 0 || busy !== 1'b0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, n);
            sbq.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        rst   = 1'b1;
        start = 1'b0;
        x     = '0;
        thr   = '0;
        neg   = 1'b0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_terms", 32'(terms_used), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        issue("s1_pos", 16'h0100, 16'h0000, 1'b0, 16'h02B5, 6, 1'b0, 18);
        wait_idle("s1_pos");
        issue("s1_neg", 16'h0100, 16'h0000, 1'b1, 16'h005F, 6, 1'b0, 18);
        wait_idle("s1_neg");
        issue("thr20", 16'h0100, 16'h0020, 1'b0, 16'h02AA, 4, 1'b0, 12);
        wait_idle("thr20");
        issue("x0", 16'h0000, 16'h1234, 1'b1, 16'h0100, 1, 1'b0, 3);
        wait_idle("x0");
        issue("sat", 16'hFF00, 16'h0000, 1'b0, 16'hFFFF, 8, 1'b1, 21);
        wait_idle("sat");
        check("hold_result", 32'(result), 32'h0000FFFF);
        check("hold_ovf", 32'(ovf), 32'd1);
        issue("x0_after_sat", 16'h0000, 16'h0000, 1'b0, 16'h0100, 1, 1'b0, 3);
        wait_idle("x0_after_sat");

        // Extra start pulses mid-run must not disturb the accepted operation.
        issue("busy_start", 16'h0100, 16'h0000, 1'b0, 16'h02B5, 6, 1'b0, 18);
        repeat (3) @(negedge clk);
        start = 1'b1;
        x     = 16'h0000;
        thr   = 16'hFFFF;
        neg   = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_idle("busy_start");
        check("busy_start_idle", 32'(busy), 32'd0);

        // Aborted run: reset lands on edge E0+7, no done may follow.
        @(negedge clk);
        x     = 16'h0100;
        thr   = 16'h0000;
        neg   = 1'b0;
        start = 1'b1;
        e0    = edge_cnt + 1;
        @(negedge clk);
        start = 1'b0;
        while (edge_cnt < e0 + 6) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_terms", 32'(terms_used), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        check("abort_quiet_result", 32'(result), 32'd0);

        issue("s1_again", 16'h0100, 16'h0000, 1'b0, 16'h02B5, 6, 1'b0, 18);
        wait_idle("s1_again");
        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exp_series_engine.md
# exp_series_engine

Self-contained, parametrised fixed-point engine that evaluates e^x or e^-x by a truncated Taylor series. Each term is built from the previous one as term·x·(1/k). The series stops early when a term falls to a caller-supplied threshold. The block owns its own FSM, reciprocal ROM, multiplier and accumulator, and uses a start/done handshake. It replaces a hand-sequenced datapath-plus-controller pair in the arithmetic subsystem.

## Interface
Parameters:
- W, default 16: data width. Unsigned fixed point with FRAC fraction bits. Requires W ≥ FRAC+2.
- FRAC, default 8: fraction bits. ONE = 2^FRAC.
- TERMS, default 8: maximum number of series terms, counting the constant 1. Range 2..16.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  request. Sampled only in IDLE.
- x  in  W  operand. Captured on the accepted start edge.
- thr  in  W  termination threshold. Captured on the accepted start edge.
- neg  in  1  mode: 0 computes e^x, 1 computes e^-x. Captured on the accepted start edge.
- busy  out  1  high from the accepted start until DONE.
- done  out  1  one-cycle pulse when the result is valid.
- result  out  W  accumulated sum. Holds until the next accepted start.
- terms_used  out  $clog2(TERMS+1)  number of terms summed, including the constant 1.
- ovf  out  1  sticky saturation/clamp flag for the current run.

## Operation
- FSM states: IDLE, MULX, MULR, ACC, DONE.
- IDLE with start=1, on the clock edge:
  - capture x, thr and neg;
  - tmp←ONE, ans←ONE, k←1, terms_used←1, ovf←0;
  - go to MULX.
- MULX: tmp ← (tmp·x)[W+FRAC-1:FRAC]. Go to MULR.
- MULR: tmp ← (tmp·R[k])[W+FRAC-1:FRAC], where R[k] = floor(2^FRAC/k) is an elaboration-time ROM for k = 1..TERMS-1. Go to ACC.
- ACC:
  - If tmp ≤ thr_r, go to DONE. The term is not added.
  - Otherwise:
    - if neg_r=1 and k is odd, ans←ans−tmp; else ans←ans+tmp;
    - terms_used increments;
    - if k = TERMS-1, go to DONE; else k increments and the FSM goes to MULX.
- DONE: done=1 for this one cycle, busy=0, then IDLE.
- Width rules:
  - Products are 2W wide and truncated, not rounded.
  - If any product bit above W+FRAC-1 is set, tmp saturates to all ones and ovf is set.
  - An add carry saturates ans to all ones and sets ovf.
  - A subtract borrow clamps ans to 0 and sets ovf.
- Boundary conditions:
  - start while busy is ignored.
  - tmp=0 with thr=0 terminates, because the compare is ≤.
  - x=0 terminates at the first ACC.
  - result and terms_used are the ans and count registers. They are unchanged from DONE until the next accepted start.

## Timing
- Reset values: state IDLE, busy 0, done 0, result 0, terms_used 0, ovf 0, tmp 0, k 0.
- rst asserted mid-run aborts immediately. No done pulse is produced.
- Call the accepted start edge E0. The ACC evaluation for term k happens on edge E0+3k, and done is high in the following cycle.
- Maximum latency is 3·(TERMS-1) edges to DONE; with defaults, done is high after edge 21. Minimum is 3 edges.
- busy is high from E0 through the ACC cycle that exits.
- The earliest next start is accepted in the cycle after DONE.
- Inputs x, thr and neg may change freely after E0.
- Single multiplier, shared by MULX and MULR. The compare and the add/sub happen only in ACC.

## Test plan
All scenarios use defaults: W=16, FRAC=8, TERMS=8.
- x=0x0100, thr=0, neg=0 -> done after edge 18, result=0x02B5, terms_used=6, ovf=0.
- x=0x0100, thr=0, neg=1 -> done after edge 18, result=0x005F, terms_used=6, ovf=0.
- x=0x0100, thr=0x0020, neg=0 -> terminates at k=4 (tmp=10), done after edge 12, result=0x02AA, terms_used=4.
- x=0x0000, any thr -> done after edge 3, result=0x0100, terms_used=1.
- x=0xFF00, thr=0, neg=0 -> runs to k=7, done after edge 21, result=0xFFFF, ovf=1, terms_used=8. The next start clears ovf.
- Reset and start edge cases:
  - start pulsed while busy -> no effect on result or timing.
  - rst asserted at edge E0+7 -> all outputs read their reset values, no done pulse.
  - a fresh start afterwards reproduces scenario 1 exactly.
